// File: rtl/eco_pkg.sv
// Shared definitions for the ECO patch extractor: sweep FSM states,
// per-output patch classification codes and the vector-count helper.
package eco_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      HOLD  = 2'd2,
      DONE  = 2'd3
   } eco_state_e;

   localparam logic [1:0] PK_NONE  = 2'b00;
   localparam logic [1:0] PK_CONST = 2'b01;
   localparam logic [1:0] PK_FUNC  = 2'b10;

   // Number of distinct {a,b} input vectors for IW-bit operands.
   function automatic int vec_count(input int iw);
      return 1 << (2 * iw);
   endfunction

endpackage

// File: rtl/eco_diff_counter.sv
// Per-output difference counter: synchronous clear has priority over
// enable; sized by the parent so it can hold the full vector count.
module eco_diff_counter #(
   parameter int W = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/eco_patch_extractor.sv
// Exhaustive golden-vs-revised sweep that recovers the ECO patch function
// w_eco = y_old ^ y_new, streams differing vectors and classifies each output.
module eco_patch_extractor
   import eco_pkg::*;
#(
   parameter int IW = 4,
   parameter int OW = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic [IW-1:0]            vec_a,
   output logic [IW-1:0]            vec_b,
   input  logic [OW-1:0]            y_old,
   input  logic [OW-1:0]            y_new,
   output logic                     diff_valid,
   input  logic                     diff_ready,
   output logic [2*IW-1:0]          diff_vec,
   output logic [OW-1:0]            diff_mask,
   output logic                     busy,
   output logic                     done,
   output logic [OW*(2*IW+1)-1:0]   diff_cnt,
   output logic [2*OW-1:0]          patch_kind
);

   localparam int VW = 2 * IW;
   localparam int CW = 2 * IW + 1;
   localparam int NV = vec_count(IW);
   localparam logic [CW-1:0] NV_CNT   = CW'(NV);
   localparam logic [VW-1:0] LAST_IDX = VW'(NV - 1);

   // Handshake: a vector transfers on a rising edge where diff_valid and
   // diff_ready are both high; diff_vec/diff_mask hold while diff_valid is up.
   eco_state_e        state_q, state_d;
   logic [VW-1:0]     idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [VW-1:0]     dvec_q, dvec_d;
   logic [OW-1:0]     dmask_q, dmask_d;
   logic              done_q, done_d;
   logic [2*OW-1:0]   pk_q, pk_d;
   logic [2*OW-1:0]   pk_class;
   logic [OW-1:0]     mism;
   logic [OW-1:0]     cnt_en;
   logic              cnt_clr;
   logic              last_vec;

   assign mism     = y_old ^ y_new;
   assign last_vec = (idx_q == LAST_IDX);

   for (genvar g = 0; g < OW; g++) begin : g_cnt
      eco_diff_counter #(.W(CW)) u_cnt (
         .clk_i (clk),
         .rst_i (rst),
         .clr_i (cnt_clr),
         .en_i  (cnt_en[g]),
         .cnt_o (diff_cnt[g*CW +: CW])
      );
   end

   // Counts are final whenever the FSM decides to enter DONE.
   always_comb begin
      pk_class = '0;
      for (int i = 0; i < OW; i++) begin
         if (diff_cnt[i*CW +: CW] == '0) begin
            pk_class[2*i +: 2] = PK_NONE;
         end else if (diff_cnt[i*CW +: CW] == NV_CNT) begin
            pk_class[2*i +: 2] = PK_CONST;
         end else begin
            pk_class[2*i +: 2] = PK_FUNC;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      dvec_d  = dvec_q;
      dmask_d = dmask_q;
      done_d  = done_q;
      pk_d    = pk_q;
      cnt_clr = 1'b0;
      cnt_en  = '0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = SWEEP;
               idx_d   = '0;
               cnt_clr = 1'b1;
               pk_d    = '0;
               done_d  = 1'b0;
            end
         end
         SWEEP: begin
            cnt_en = mism;
            if (mism != '0) begin
               dvec_d  = idx_q;
               dmask_d = mism;
               valid_d = 1'b1;
               state_d = HOLD;
            end else if (last_vec) begin
               state_d = DONE;
               done_d  = 1'b1;
               pk_d    = pk_class;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         HOLD: begin
            if (valid_q && diff_ready) begin
               valid_d = 1'b0;
               if (last_vec) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  pk_d    = pk_class;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = SWEEP;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         dvec_q  <= '0;
         dmask_q <= '0;
         done_q  <= 1'b0;
         pk_q    <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         dvec_q  <= dvec_d;
         dmask_q <= dmask_d;
         done_q  <= done_d;
         pk_q    <= pk_d;
      end
   end

   assign vec_a      = idx_q[VW-1:IW];
   assign vec_b      = idx_q[IW-1:0];
   assign diff_valid = valid_q;
   assign diff_vec   = dvec_q;
   assign diff_mask  = dmask_q;
   assign busy       = (state_q == SWEEP) || (state_q == HOLD);
   assign done       = done_q;
   assign patch_kind = pk_q;

endmodule

// File: doc/eco_patch_extractor.md
# eco_patch_extractor

Sequential ECO rectification extractor for the gate-change flow. It exhaustively sweeps every input vector of a small combinational block and drives the same vector into the original (golden) netlist and the revised (patched) netlist. Where outputs differ, it computes the per-output patch function `eco = y_old ^ y_new` and streams the differing vectors out. It also classifies each output's patch as none, constant-invert or functional. This is the decode side of patch insertion: the patched netlist applies `y = orig ^ w_eco`, and this block recovers `w_eco`.

## Interface
Parameters:
- `IW`, default 4: width of each operand `a` and `b`.
- `OW`, default 4: number of outputs `y` compared.
- `NV`: derived, `2**(2*IW)`, the vector count. Not overridable.

Ports:
- `clk`, in, 1: single clock. All state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse; begins a sweep when in IDLE or DONE.
- `vec_a`, out, IW: operand a, driven into both netlists.
- `vec_b`, out, IW: operand b, driven into both netlists.
- `y_old`, in, OW: golden netlist output, combinational from `vec_a`/`vec_b`.
- `y_new`, in, OW: revised netlist output, combinational from `vec_a`/`vec_b`.
- `diff_valid`, out, 1: a differing vector is presented.
- `diff_ready`, in, 1: consumer accepts the presented vector.
- `diff_vec`, out, 2*IW: the differing vector, packed as `{a,b}`.
- `diff_mask`, out, OW: `y_old ^ y_new` for that vector.
- `busy`, out, 1: high in SWEEP or HOLD.
- `done`, out, 1: high in DONE until the next `start`.
- `diff_cnt`, out, OW*(2*IW+1): per-output count of differing vectors. Output i occupies slice i.
- `patch_kind`, out, 2*OW: per-output code. 00 = none, 01 = constant-invert, 10 = functional, 11 unused.

## Operation
- Reset values: all outputs are 0. `vec_a`/`vec_b` are 0 and the state is IDLE.
- `vec_a`/`vec_b` are registered from the vector counter `idx`: `vec_a = idx[2*IW-1:IW]`, `vec_b = idx[IW-1:0]`.
- The `y_*` inputs are compared in the same cycle the vector is presented.
- States:
  - IDLE: on `start`, clear `idx`, all `diff_cnt` and `patch_kind`, then go to SWEEP.
  - SWEEP: compute `m = y_old ^ y_new`.
    - For each set bit of `m`, increment that output's `diff_cnt` by 1.
    - If `m != 0`, load `diff_vec = idx` and `diff_mask = m`, assert `diff_valid`, and go to HOLD.
    - Else, if `idx == NV-1`, go to DONE. Otherwise `idx++`.
  - HOLD: keep `diff_valid`, `diff_vec` and `diff_mask` stable and keep the vector outputs frozen.
    - When `diff_valid && diff_ready`, drop `diff_valid`.
    - Then go to DONE if `idx == NV-1`. Otherwise `idx++` and return to SWEEP.
  - DONE: `done = 1` and `patch_kind` is valid. On `start`, behave as in IDLE.
- Classification, computed on entry to DONE:
  - `diff_cnt == 0` gives 00.
  - `diff_cnt == NV` gives 01.
  - Any other count gives 10.
- Counter width: 2*IW+1 bits so that exactly NV is representable. Counters never wrap.
- `start` while `busy` is ignored.
- Asynchronous `rst` mid-sweep: immediate return to IDLE, all outputs 0. No partial results are retained.
- Handshake: `diff_valid` never drops without a transfer. `diff_vec` and `diff_mask` are constant while `diff_valid` is high.

## Timing
- One vector per cycle while no diffs occur.
- A clean sweep (no diffs) takes NV cycles in SWEEP. `done` rises on cycle NV+1 after the `start` edge.
- Each differing vector adds at least one HOLD cycle. A HOLD with `diff_ready` already high costs exactly 1 extra cycle.
- `diff_valid` rises on the clock edge after the differing vector is presented.
- `patch_kind` and final `diff_cnt` are valid in the same cycle `done` rises.

## Structure
- Shared package `eco_pkg`:
  - state enum `{IDLE, SWEEP, HOLD, DONE}`;
  - patch-kind codes `PK_NONE`, `PK_CONST`, `PK_FUNC`;
  - function `vec_count(iw)`.
- One sub-module, `eco_diff_counter`: a per-output saturating-free counter with clear and enable, instantiated OW times.
- FSM, vector counter and output register stay in the top.

## Test plan
- Identical netlists (`y_new = y_old`), `diff_ready = 1`:
  - `done` at cycle 257;
  - every `diff_cnt` is 0;
  - `patch_kind` is `8'b00000000`;
  - `diff_valid` never asserted.
- Revised `y[2]` inverted (`w_eco = 1'b1`):
  - `diff_cnt[2]` is 256 and `patch_kind[5:4]` is 01;
  - 256 transfers, each with `diff_mask = 4'b0100`.
- Revised `y[3]` XORed with `b[3] | ~(a[3]^b[1])`, all other outputs unchanged:
  - `diff_cnt[3]` equals the 0-to-1 population of that function over 256 vectors;
  - `patch_kind[7:6]` is 10;
  - every `diff_vec` satisfies the function.
- `diff_ready` held low for 5 cycles on the first diff:
  - `diff_vec`/`diff_mask` stable throughout;
  - `vec_a`/`vec_b` frozen;
  - exactly one transfer.
- `rst` asserted at vector 100 → outputs 0 the same cycle. A new `start` gives a full clean sweep from `idx` 0.
- `start` pulsed during SWEEP has no effect. `start` in DONE clears the counters and restarts.
